joy_conditioner: RTL
====================

# joy_conditioner

Conditions the two raw active-low joystick words produced by the serial joystick decoder before the console core sees them. It resynchronises them into the core clock domain, debounces each switch, and optionally applies player swap and autofire. It also presents the player selected by the CPU as the 5-bit Videopac joystick nibble. It sits between the joystick decoder and the 8048 port/bus read logic.

## Interface
Parameters:
- TICK_DIV, 1024: `clk` cycles per sample tick (≥2).
- DEBOUNCE_TICKS, 16: consecutive disagreeing ticks needed to accept a new switch level (≥1).
- AUTOFIRE_DIV, 4: sample ticks per autofire half-period (≥1).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- joy1_raw  in  8  player-1 word from the decoder, active-low: bit0 right, bit1 left, bit2 down, bit3 up, bit4 fire1, bit5 fire2, bits 7:6 don't-care. Asynchronous to `clk`.
- joy2_raw  in  8  player-2 word, same layout.
- swap  in  1  1 = exchange players after debounce.
- autofire_on  in  2  per-player autofire enable on fire1 (bit0 = player 1).
- joy_sel  in  1  player presented on `joy_bus` (0 = player 1).
- joy1_clean  out  8  debounced, post-swap player-1 word, same layout; bits 7:6 forced 1.
- joy2_clean  out  8  as above, player 2.
- joy_bus  out  5  active-low Videopac nibble for the selected player: bit0 up, bit1 right, bit2 down, bit3 left, bit4 fire.
- changed  out  1  single-cycle pulse when any output bit changes.

## Operation
- Synchroniser: two flops per used input bit (bits 5:0 of each player, 12 bits total). Both flops reset to 1.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when the count equals TICK_DIV-1.
- Debounce: each of the 12 bits has a level `clean` (reset 1) and a counter `cnt` (reset 0, width clog2(DEBOUNCE_TICKS+1)). The counter is evaluated only on `tick`:
  - sync == clean: cnt ← 0.
  - sync ≠ clean and cnt == DEBOUNCE_TICKS-1: clean ← sync, cnt ← 0.
  - otherwise: cnt ← cnt+1.
  - Any agreeing tick discards a partial count.
- Swap: player A = swap ? player-2 clean : player-1 clean. Player B is the other one. `swap` is sampled every cycle.
- Autofire: see Configuration. It modifies fire1 of A and B after the swap, so the enable follows the physical port position.
- Output stage (all registered):
  - joy1_clean ← {2'b11, A}.
  - joy2_clean ← {2'b11, B}.
  - `joy_bus` is built from P = joy_sel ? B : A:
    - up = P[3], right = P[0], down = P[2], left = P[1].
    - fire = P[4] & P[5], so either fire button pressed reports fire.
    - If up and down are both pressed (0), both report released (1). The same rule applies to left and right.
  - changed ← 1 for one cycle whenever the new value of {joy1_clean, joy2_clean, joy_bus} differs from the current registered value.

## Timing
- Reset (asynchronous assert, synchronous release): joy1_clean = 8'hFF, joy2_clean = 8'hFF, joy_bus = 5'h1F, changed = 0. The prescaler, all debounce counters and the autofire state clear to 0.
- Reset asserted mid-debounce or mid-burst abandons all progress. After release the prescaler restarts from 0.
- Raw → clean latency: 2 cycles of synchronisation, then DEBOUNCE_TICKS ticks, then 1 output-register cycle.
- `swap`, `joy_sel` and `autofire_on` take effect on the outputs 1 cycle after they are sampled, with no debounce.
- A raw pulse shorter than 1 tick may never be seen. A disagreement spanning fewer than DEBOUNCE_TICKS consecutive ticks is never accepted.
- A swap and a debounce update in the same cycle both appear in the same output update, with a single `changed` pulse.

## Configuration
- JOY_AUTOFIRE_EN defined:
  - Each player has a phase flop and a tick counter running 0..AUTOFIRE_DIV-1.
  - While autofire_on[p] = 1 and clean fire1 = 0, the counter advances on `tick`. The phase toggles each time the counter wraps.
  - Reported fire1 = phase (phase 0 = pressed), so the first press is reported immediately.
  - When fire1 is released or autofire is off: phase ← 0, counter ← 0, and fire1 passes through unchanged.
- JOY_AUTOFIRE_EN undefined:
  - The `autofire_on` port remains present but is ignored.
  - fire1 always passes through unchanged and no autofire logic is synthesised.

## Test plan
Use TICK_DIV = 4, DEBOUNCE_TICKS = 3, AUTOFIRE_DIV = 2.
- Reset: hold reset_n low with raw inputs 8'h00 → outputs are 8'hFF / 8'hFF / 5'h1F with changed = 0. After release, joy1_clean becomes 8'hC0 within 2 + 12 + 1 cycles. `changed` pulses exactly once.
- Glitch rejection: joy1_raw bit0 low for 2 ticks, then high → joy1_clean stays 8'hFF and changed stays 0. Bit0 low for 3 ticks → joy1_clean = 8'hFE and joy_bus = 5'h1D (right, joy_sel = 0).
- SOCD: joy2_raw = 8'hF3 (up and down pressed), joy_sel = 1 after debounce → joy_bus = 5'h1F while joy2_clean = 8'hF3.
- Swap: player 1 fire2 held (joy1_clean = 8'hDF). Set swap = 1 → on the next cycle joy1_clean = 8'hFF, joy2_clean = 8'hDF, with one changed pulse.
- Autofire (macro defined): autofire_on = 2'b01, player-1 fire1 held → joy_bus[4] reads 0, 1, 0, … toggling every 2 ticks, starting at 0. On release it returns to 1 and the phase restarts.
- Asynchronous reset mid-burst, then re-press → the first reported fire is immediately 0.

Source files
------------

// File: rtl/joy_conditioner.sv
// Joystick conditioner: resynchronise, debounce, swap and optional autofire for two
// active-low joystick words, plus the Videopac nibble. Autofire is built when JOY_AUTOFIRE_EN is defined.
module joy_conditioner #(
  parameter int TICK_DIV       = 1024,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int AUTOFIRE_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] joy1_raw,
  input  logic [7:0] joy2_raw,
  input  logic       swap,
  input  logic [1:0] autofire_on,
  input  logic       joy_sel,
  output logic [7:0] joy1_clean,
  output logic [7:0] joy2_clean,
  output logic [4:0] joy_bus,
  output logic       changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [11:0]   sync1_r, sync2_r, clean_r;
  logic [CW-1:0] cnt_r [12];
  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic [5:0]    pa_s, pb_s, fa_s, fb_s;
  logic [7:0]    j1_nxt_s, j2_nxt_s;
  logic [4:0]    bus_nxt_s;
  logic          unused_s;

  assign unused_s = ^{joy1_raw[7:6], joy2_raw[7:6]};

  // Directions opposing each other cancel to released; either fire button reports fire.
  function automatic logic [4:0] to_bus(input logic [5:0] p);
    logic socd_ud, socd_lr;
    socd_ud = ~p[3] & ~p[2];
    socd_lr = ~p[1] & ~p[0];
    return {p[4] & p[5], p[1] | socd_lr, p[2] | socd_ud, p[0] | socd_lr, p[3] | socd_ud};
  endfunction

  // Two-flop synchroniser for the 12 used raw bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 12'hFFF;
      sync2_r <= 12'hFFF;
    end else begin
      sync1_r <= {joy2_raw[5:0], joy1_raw[5:0]};
      sync2_r <= sync1_r;
    end
  end

  assign tick_s = (presc_r == PW'(TICK_DIV - 1));

  // Sample-tick prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Per-bit debounce: a disagreement must persist for DEBOUNCE_TICKS consecutive ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_r <= 12'hFFF;
      for (int i = 0; i < 12; i++) cnt_r[i] <= '0;
    end else if (tick_s) begin
      for (int i = 0; i < 12; i++) begin
        if (sync2_r[i] == clean_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CW'(DEBOUNCE_TICKS - 1)) begin
          clean_r[i] <= sync2_r[i];
          cnt_r[i]   <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign pa_s = swap ? clean_r[11:6] : clean_r[5:0];
  assign pb_s = swap ? clean_r[5:0]  : clean_r[11:6];

`ifdef JOY_AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

  logic [1:0]    phase_r;
  logic [AW-1:0] af_cnt_r [2];
  logic [1:0]    af_act_s;

  // Autofire follows the post-swap position, so enable bit 0 drives output player 1
  assign af_act_s = {autofire_on[1] & ~pb_s[4], autofire_on[0] & ~pa_s[4]};

  // Autofire phase and half-period counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= 2'b00;
      for (int p = 0; p < 2; p++) af_cnt_r[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (!af_act_s[p]) begin
          phase_r[p]  <= 1'b0;
          af_cnt_r[p] <= '0;
        end else if (tick_s) begin
          if (af_cnt_r[p] == AW'(AUTOFIRE_DIV - 1)) begin
            af_cnt_r[p] <= '0;
            phase_r[p]  <= ~phase_r[p];
          end else begin
            af_cnt_r[p] <= af_cnt_r[p] + AW'(1);
          end
        end
      end
    end
  end

  // Substitute the autofire phase for fire1 while active
  always_comb begin
    fa_s = pa_s;
    fb_s = pb_s;
    if (af_act_s[0]) begin
      fa_s[4] = phase_r[0];
    end else begin
      fa_s[4] = pa_s[4];
    end
    if (af_act_s[1]) begin
      fb_s[4] = phase_r[1];
    end else begin
      fb_s[4] = pb_s[4];
    end
  end
`else
  logic unused_af_s;
  assign unused_af_s = ^autofire_on;
  assign fa_s = pa_s;
  assign fb_s = pb_s;
`endif

  // Next output values
  always_comb begin
    j1_nxt_s  = {2'b11, fa_s};
    j2_nxt_s  = {2'b11, fb_s};
    bus_nxt_s = to_bus(joy_sel ? fb_s : fa_s);
  end

  // Registered outputs and change strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy1_clean <= 8'hFF;
      joy2_clean <= 8'hFF;
      joy_bus    <= 5'h1F;
      changed    <= 1'b0;
    end else begin
      joy1_clean <= j1_nxt_s;
      joy2_clean <= j2_nxt_s;
      joy_bus    <= bus_nxt_s;
      changed    <= ({j1_nxt_s, j2_nxt_s, bus_nxt_s} != {joy1_clean, joy2_clean, joy_bus});
    end
  end

endmodule
